data_mem_arbiter: RTL

Shares the single-port data RAM between the CPU load/store path and a secondary DMA/loader requester. It sits between the CPU datapath (ALU address, RD2 write data, Data_WE) and data_ram, and owns the RAM port every cycle. It stalls the CPU while the DMA port holds a burst, and it forces a DMA grant when the DMA port has been starved too long. CPU accesses stay zero-latency: RAM read data returns in the same cycle. DMA read data is registered and returns one cycle after the grant.

---
 rtl/data_mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// The CPU load/store path and a DMA/loader requester share one single-port
// data RAM through this block. CPU accesses are zero-latency. DMA beats can
// be grouped into bursts, and a burst locks the CPU out until it ends. A
// starvation counter forces a DMA grant when the CPU has held the port for
// MAX_WAIT cycles while DMA was asking.

module data_mem_arbiter #(
    parameter int D_WIDTH   = 32,
    parameter int BURST_MAX = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    // CPU load/store side
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [D_WIDTH-1:0] cpu_addr,
    input  logic [D_WIDTH-1:0] cpu_wd,
    output logic [D_WIDTH-1:0] cpu_rd,
    output logic               cpu_stall,
    // DMA / loader side
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [D_WIDTH-1:0] dma_addr,
    input  logic [D_WIDTH-1:0] dma_wd,
    input  logic               dma_last,
    output logic               dma_gnt,
    output logic [D_WIDTH-1:0] dma_rdata,
    output logic               dma_rvalid,
    output logic               burst_active,
    // RAM port
    output logic               Data_WE,
    output logic [D_WIDTH-1:0] Data_addr,
    output logic [D_WIDTH-1:0] Data_WD,
    input  logic [D_WIDTH-1:0] Data_RD
);

    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LIM  = BEAT_W'(BURST_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);

    // A burst only makes sense if more than one beat is allowed. With a
    // one-beat limit, every DMA grant is a single transfer from IDLE.
    localparam logic BURST_EN = (BURST_MAX > 1) ? 1'b1 : 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [BEAT_W-1:0]   w_beat_inc;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [D_WIDTH-1:0]  r_dma_rdata;
    logic                r_dma_rvalid;

    logic                w_cpu_gnt;
    logic                w_dma_gnt;
    logic                w_forced;
    logic                w_dma_read;

    // A forced grant happens when DMA is still asking and has already waited
    // the full starvation budget.
    assign w_forced   = dma_req & (r_wait_cnt == WAIT_LIM);
    assign w_beat_inc = r_beat_cnt + BEAT_ONE;
    assign w_dma_read = w_dma_gnt & ~dma_we;

    // Grant selection: at most one owner per cycle. A burst owns the port.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_forced) begin
                    w_dma_gnt = 1'b1;
                end else if (cpu_req) begin
                    w_cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    w_dma_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b0;
                    w_dma_gnt = 1'b0;
                end
            end
            ST_BURST: begin
                // The CPU stays locked out for the whole burst.
                w_dma_gnt = dma_req;
            end
            default: begin
                w_cpu_gnt = 1'b0;
                w_dma_gnt = 1'b0;
            end
        endcase
    end

    // RAM port mux. CPU inputs drive the port whenever DMA is not the owner,
    // so an idle port shows the CPU address without writing.
    always_comb begin
        Data_WE   = 1'b0;
        Data_addr = cpu_addr;
        Data_WD   = cpu_wd;
        if (w_dma_gnt) begin
            Data_WE   = dma_we;
            Data_addr = dma_addr;
            Data_WD   = dma_wd;
        end else begin
            Data_WE   = cpu_we & w_cpu_gnt;
            Data_addr = cpu_addr;
            Data_WD   = cpu_wd;
        end
    end

    // Next-state, beat count and starvation count.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = BEAT_ZERO;
                if (w_dma_gnt) begin
                    w_wait_nxt = WAIT_ZERO;
                    if (!dma_last && BURST_EN) begin
                        w_state_nxt = ST_BURST;
                        w_beat_nxt  = BEAT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (dma_req && (r_wait_cnt != WAIT_LIM)) begin
                    w_wait_nxt = r_wait_cnt + WAIT_ONE;
                end else begin
                    // Saturate while starved. Hold while DMA is quiet.
                    w_wait_nxt = r_wait_cnt;
                end
            end
            ST_BURST: begin
                if (!dma_req) begin
                    // The requester walked away mid-burst, so release the port.
                    w_state_nxt = ST_IDLE;
                    w_beat_nxt  = BEAT_ZERO;
                    w_wait_nxt  = WAIT_ZERO;
                end else if (dma_last || (w_beat_inc == BEAT_LIM)) begin
                    w_state_nxt = ST_IDLE;
                    w_beat_nxt  = BEAT_ZERO;
                    w_wait_nxt  = WAIT_ZERO;
                end else begin
                    w_state_nxt = ST_BURST;
                    w_beat_nxt  = w_beat_inc;
                    w_wait_nxt  = WAIT_ZERO;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = BEAT_ZERO;
                w_wait_nxt  = WAIT_ZERO;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= BEAT_ZERO;
            r_wait_cnt <= WAIT_ZERO;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // DMA read return path. It captures RAM data one cycle after a read grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dma_rdata  <= {D_WIDTH{1'b0}};
            r_dma_rvalid <= 1'b0;
        end else if (w_dma_read) begin
            r_dma_rdata  <= Data_RD;
            r_dma_rvalid <= 1'b1;
        end else begin
            r_dma_rdata  <= r_dma_rdata;
            r_dma_rvalid <= 1'b0;
        end
    end

    assign cpu_rd       = Data_RD;
    assign cpu_stall    = cpu_req & ~w_cpu_gnt;
    assign dma_gnt      = w_dma_gnt;
    assign dma_rdata    = r_dma_rdata;
    assign dma_rvalid   = r_dma_rvalid;
    assign burst_active = (r_state == ST_BURST);

endmodule
